// File: rtl/game_state_tracker.sv
// Per-player board spot and score tracker with handshaked updates, sequential
// double-dabble BCD of the active player's score, and a sequential winner scan.
module game_state_tracker #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned NUM_SPOTS   = 24,
  parameter int unsigned SPOT_W      = 5,
  parameter int unsigned MOVE_W      = 4,
  parameter int unsigned DELTA_W     = 9,
  parameter int unsigned SCORE_W     = 14,
  parameter int unsigned SCORE_MAX   = 9999,
  parameter int unsigned LAP_BONUS   = 20,
  localparam int unsigned PW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               new_game,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [MOVE_W-1:0]  upd_moves,
  input  logic [DELTA_W-1:0] upd_delta,
  input  logic               upd_neg,
  input  logic               upd_end_turn,
  input  logic               win_req,
  output logic               win_valid,
  output logic [PW-1:0]      win_player,
  output logic [SCORE_W-1:0] win_score,
  output logic [PW-1:0]      cur_turn,
  output logic [SPOT_W-1:0]  cur_spot,
  output logic [SCORE_W-1:0] cur_score,
  output logic [15:0]        bcd,
  output logic               bcd_valid
);

  localparam int unsigned SUM_W = SPOT_W + 1;
  localparam int unsigned SW2   = SCORE_W + 2;
  localparam int unsigned CNT_W = $clog2(SCORE_W);

  typedef enum logic [1:0] {IDLE, APPLY, BCD, SCAN} state_t;

  state_t state, state_n;

  logic [SPOT_W-1:0]  spot_q  [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic               pending_q;
  logic [MOVE_W-1:0]  moves_q;
  logic [DELTA_W-1:0] delta_q;
  logic               neg_q;
  logic               end_q;
  logic [SCORE_W-1:0] bin_q;
  logic [15:0]        dd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PW-1:0]      scan_idx_q;
  logic [PW-1:0]      best_idx_q;
  logic [SCORE_W-1:0] best_score_q;

  logic               accept;
  logic [PW-1:0]      next_turn;
  logic [SUM_W-1:0]   sum;
  logic               wrap;
  logic [SPOT_W-1:0]  new_spot;
  logic [SW2-1:0]     s_sum;
  logic [SCORE_W-1:0] new_score;
  logic [SCORE_W-1:0] conv_src;
  logic [15:0]        dd_adj;
  logic [15:0]        dd_next;
  logic               bcd_last;
  logic [SCORE_W-1:0] scan_score;
  logic               scan_take;
  logic               scan_last;

  assign upd_ready = (state == IDLE) && !new_game;
  assign accept    = upd_valid && upd_ready;
  assign cur_spot  = spot_q[cur_turn];
  assign cur_score = score_q[cur_turn];

  // Move/score arithmetic for the active player, evaluated while in APPLY.
  always_comb begin
    next_turn = (cur_turn == PW'(NUM_PLAYERS - 1)) ? '0 : cur_turn + PW'(1);
    sum       = SUM_W'(spot_q[cur_turn]) + SUM_W'(moves_q);
    wrap      = (sum >= SUM_W'(NUM_SPOTS));
    new_spot  = wrap ? SPOT_W'(sum - SUM_W'(NUM_SPOTS)) : SPOT_W'(sum);
    s_sum     = SW2'(score_q[cur_turn]) + (wrap ? SW2'(LAP_BONUS) : '0);
    s_sum     = neg_q ? s_sum - SW2'(delta_q) : s_sum + SW2'(delta_q);
    if (s_sum[SW2-1])
      new_score = '0;
    else if (s_sum > SW2'(SCORE_MAX))
      new_score = SCORE_W'(SCORE_MAX);
    else
      new_score = s_sum[SCORE_W-1:0];
    // After an end-of-turn update the displayed score belongs to the next player.
    conv_src  = end_q ? score_q[next_turn] : new_score;
  end

  // One double-dabble step: add 3 to digits >= 5, then shift the next bit in.
  always_comb begin
    dd_adj = dd_q;
    for (int k = 0; k < 4; k++) begin
      if (dd_q[4*k +: 4] >= 4'd5)
        dd_adj[4*k +: 4] = dd_q[4*k +: 4] + 4'd3;
    end
    dd_next  = {dd_adj[14:0], bin_q[SCORE_W-1]};
    bcd_last = (state == BCD) && (cnt_q == CNT_W'(SCORE_W - 1));
  end

  always_comb begin
    scan_score = score_q[scan_idx_q];
    scan_take  = (scan_idx_q == '0) || (scan_score > best_score_q);
    scan_last  = (state == SCAN) && (scan_idx_q == PW'(NUM_PLAYERS - 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (new_game) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (accept) state_n = APPLY;
               else if (pending_q) state_n = SCAN;
        APPLY: state_n = BCD;
        BCD:   if (bcd_last) state_n = IDLE;
        SCAN:  if (scan_last) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        spot_q[i]  <= '0;
        score_q[i] <= '0;
      end
      cur_turn     <= '0;
      pending_q    <= 1'b0;
      moves_q      <= '0;
      delta_q      <= '0;
      neg_q        <= 1'b0;
      end_q        <= 1'b0;
      bin_q        <= '0;
      dd_q         <= '0;
      cnt_q        <= '0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      bcd          <= '0;
      bcd_valid    <= 1'b1;
      win_valid    <= 1'b0;
      win_player   <= '0;
      win_score    <= '0;
    end else if (new_game) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        spot_q[i]  <= '0;
        score_q[i] <= '0;
      end
      cur_turn   <= '0;
      pending_q  <= 1'b0;
      bcd        <= '0;
      bcd_valid  <= 1'b1;
      win_valid  <= 1'b0;
      win_player <= '0;
      win_score  <= '0;
    end else begin
      win_valid <= 1'b0;
      if (win_req) pending_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            moves_q <= upd_moves;
            delta_q <= upd_delta;
            neg_q   <= upd_neg;
            end_q   <= upd_end_turn;
          end else if (pending_q) begin
            pending_q  <= 1'b0;
            scan_idx_q <= '0;
          end
        end
        APPLY: begin
          spot_q[cur_turn]  <= new_spot;
          score_q[cur_turn] <= new_score;
          if (end_q) cur_turn <= next_turn;
          bin_q     <= conv_src;
          dd_q      <= '0;
          cnt_q     <= '0;
          bcd_valid <= 1'b0;
        end
        BCD: begin
          bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
          dd_q  <= dd_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (bcd_last) begin
            bcd       <= dd_next;
            bcd_valid <= 1'b1;
          end
        end
        SCAN: begin
          if (scan_take) begin
            best_idx_q   <= scan_idx_q;
            best_score_q <= scan_score;
          end
          scan_idx_q <= scan_idx_q + PW'(1);
          if (scan_last) begin
            win_player <= scan_take ? scan_idx_q : best_idx_q;
            win_score  <= scan_take ? scan_score : best_score_q;
            win_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_tracker.sv
// Scoreboard bench for game_state_tracker: driver pushes reference-model
// expectations, a negedge monitor pops them on bcd_valid rise / win_valid.
module tb_game_state_tracker;

  localparam int NP = 4;
  localparam int NS = 24;
  localparam int SCORE_W = 14;
  localparam int SMAX = 9999;
  localparam int BONUS = 20;

  logic        clk, resetn, new_game, upd_valid, upd_ready, upd_neg, upd_end_turn;
  logic [3:0]  upd_moves;
  logic [8:0]  upd_delta;
  logic        win_req, win_valid, bcd_valid;
  logic [1:0]  win_player, cur_turn;
  logic [13:0] win_score, cur_score;
  logic [4:0]  cur_spot;
  logic [15:0] bcd;

  game_state_tracker dut (
    .clk(clk), .resetn(resetn), .new_game(new_game),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_moves(upd_moves),
    .upd_delta(upd_delta), .upd_neg(upd_neg), .upd_end_turn(upd_end_turn),
    .win_req(win_req), .win_valid(win_valid), .win_player(win_player),
    .win_score(win_score), .cur_turn(cur_turn), .cur_spot(cur_spot),
    .cur_score(cur_score), .bcd(bcd), .bcd_valid(bcd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int turn; int spot; int score; int bcdv; } upd_exp_t;
  typedef struct { int player; int score; } win_exp_t;

  upd_exp_t upd_q[$];
  win_exp_t win_q[$];
  int m_spot[NP];
  int m_score[NP];
  int m_turn;
  int n_cmp = 0;
  int n_err = 0;
  bit prev_wv = 1'b0;
  bit prev_bv = 1'b1;
  bit ng_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      m_spot[i] = 0;
      m_score[i] = 0;
    end
    m_turn = 0;
  endtask

  task automatic model_update(input int mv, input int dl, input int ng, input int et);
    upd_exp_t e;
    int s;
    int pos;
    pos = m_spot[m_turn] + mv;
    s = m_score[m_turn];
    if (pos >= NS) begin
      pos -= NS;
      s += BONUS;
    end
    s = ng ? s - dl : s + dl;
    if (s < 0) s = 0;
    if (s > SMAX) s = SMAX;
    m_spot[m_turn] = pos;
    m_score[m_turn] = s;
    if (et) m_turn = (m_turn + 1) % NP;
    e.turn = m_turn;
    e.spot = m_spot[m_turn];
    e.score = m_score[m_turn];
    e.bcdv = to_bcd(m_score[m_turn]);
    upd_q.push_back(e);
  endtask

  // Winner = lowest index holding the maximum score.
  task automatic push_win();
    win_exp_t w;
    int mx;
    mx = m_score[0];
    foreach (m_score[i]) if (m_score[i] > mx) mx = m_score[i];
    w.player = -1;
    foreach (m_score[i]) if (w.player < 0 && m_score[i] == mx) w.player = i;
    w.score = mx;
    win_q.push_back(w);
  endtask

  task automatic do_update(input int mv, input int dl, input int ng, input int et, input bit with_win);
    int guard;
    int low;
    guard = 0;
    while (!upd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!upd_ready) begin
      $display("FAIL upd_ready_timeout: got 0 expected 1");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
      $fatal(1, "upd_ready never returned");
    end
    upd_valid = 1'b1;
    upd_moves = 4'(mv);
    upd_delta = 9'(dl);
    upd_neg = ng[0];
    upd_end_turn = et[0];
    win_req = with_win;
    @(posedge clk);
    model_update(mv, dl, ng, et);
    if (with_win) push_win();
    @(negedge clk);
    upd_valid = 1'b0;
    win_req = 1'b0;
    upd_moves = 4'($urandom);
    upd_delta = 9'($urandom);
    low = 0;
    while (!upd_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
    chk("busy_cycles", low, SCORE_W + 1);
  endtask

  task automatic wait_win();
    int guard;
    guard = 0;
    while (win_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("win_arrived", win_q.size(), 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_bcd"}, int'(bcd), 0);
    chk({tag, "_bcd_valid"}, int'(bcd_valid), 1);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_win_player"}, int'(win_player), 0);
    chk({tag, "_win_score"}, int'(win_score), 0);
    chk({tag, "_cur_turn"}, int'(cur_turn), 0);
    chk({tag, "_cur_spot"}, int'(cur_spot), 0);
    chk({tag, "_cur_score"}, int'(cur_score), 0);
  endtask

  always @(posedge clk) ng_prev <= new_game;

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    if (resetn) begin
      if (prev_wv) chk("win_valid_pulse", int'(win_valid), 0);
      if (win_valid) begin
        if (win_q.size() == 0) begin
          chk("unexpected_win_valid", 1, 0);
        end else begin
          win_exp_t w;
          w = win_q.pop_front();
          chk("win_player", int'(win_player), w.player);
          chk("win_score", int'(win_score), w.score);
          chk("update_before_scan", upd_q.size(), 0);
        end
      end
      if (bcd_valid && !prev_bv && !ng_prev) begin
        if (upd_q.size() == 0) begin
          chk("unexpected_bcd_valid", 1, 0);
        end else begin
          upd_exp_t e;
          e = upd_q.pop_front();
          chk("cur_turn", int'(cur_turn), e.turn);
          chk("cur_spot", int'(cur_spot), e.spot);
          chk("cur_score", int'(cur_score), e.score);
          chk("bcd", int'(bcd), e.bcdv);
        end
      end
    end
    prev_wv = win_valid;
    prev_bv = bcd_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    new_game = 1'b0;
    upd_valid = 1'b0;
    upd_moves = '0;
    upd_delta = '0;
    upd_neg = 1'b0;
    upd_end_turn = 1'b0;
    win_req = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_cleared("reset");
    chk("reset_upd_ready", int'(upd_ready), 1);

    // First update, then walk the turn back to player 0.
    do_update(3, 7, 0, 1, 1'b0);
    for (int i = 0; i < 3; i++) do_update(0, 0, 0, 1, 1'b0);

    // Lap wrap: 3 -> 18 -> 22 -> 3 with bonus.
    do_update(15, 0, 0, 0, 1'b0);
    do_update(4, 0, 0, 0, 1'b0);
    do_update(5, 0, 0, 0, 1'b0);

    // Saturation at both ends.
    do_update(0, 22, 1, 0, 1'b0);
    do_update(0, 9, 1, 0, 1'b0);
    for (int i = 0; i < 20; i++) do_update(0, 500, 0, 0, 1'b0);
    do_update(0, 4, 1, 0, 1'b0);
    do_update(0, 9, 0, 0, 1'b0);

    // new_game mid-BCD aborts the conversion.
    upd_valid = 1'b1;
    upd_moves = 4'd2;
    upd_delta = 9'd11;
    upd_neg = 1'b0;
    upd_end_turn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    repeat (4) @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    new_game = 1'b0;
    #1;
    check_cleared("ng_bcd");
    chk("ng_bcd_upd_ready", int'(upd_ready), 1);

    // Ties and turn wrap, then an idle scan.
    do_update(0, 10, 0, 1, 1'b0);
    do_update(0, 30, 0, 1, 1'b0);
    do_update(0, 30, 0, 1, 1'b0);
    do_update(0, 5, 0, 1, 1'b0);
    win_req = 1'b1;
    push_win();
    @(negedge clk);
    win_req = 1'b0;
    wait_win();

    // new_game in IDLE clears the held winner.
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    new_game = 1'b0;
    #1;
    check_cleared("ng_idle");

    // Update and win request in the same cycle.
    do_update(7, 40, 0, 0, 1'b1);
    wait_win();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      bit w;
      w = ($urandom_range(0, 3) == 0);
      do_update($urandom_range(0, 15), $urandom_range(0, 511), $urandom_range(0, 2) == 0 ? 1 : 0,
                $urandom_range(0, 1), w);
      if (w) wait_win();
      if ($urandom_range(0, 4) == 0) begin
        win_req = 1'b1;
        push_win();
        @(negedge clk);
        win_req = 1'b0;
        wait_win();
      end
    end

    // Async reset in the middle of a scan: no result may follow.
    win_req = 1'b1;
    @(negedge clk);
    win_req = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_cleared("async_rst");
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_upd_ready", int'(upd_ready), 1);

    chk("upd_queue_drained", upd_q.size(), 0);
    chk("win_queue_drained", win_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
